// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and debounced key-code signal bundle
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       multi_key;

  modport master (
    input  rows,
    output cols, key_code, key_valid, multi_key
  );

  modport slave (
    output rows,
    input  cols, key_code, key_valid, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with multi-scan debounce
// Optional feature macro: KEYPAD_MULTI_DETECT_EN (reject and flag multi-key scans)
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master kp
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TLAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DB    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

  logic [3:0]    rs1_q, rs2_q;
  logic [TW-1:0] tcnt_q;
  logic [1:0]    col_q;
  logic          acc_any_q;
  logic [3:0]    acc_idx_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d, code_q, code_d;
  logic          key_valid_q, key_valid_d;
  logic          multi_q;

  logic       scan_end, scan_done, single;
  logic       col_hit, new_any, new_multi;
  logic [1:0] col_row;
  logic [3:0] col_idx, new_idx, pressed;

  assign pressed   = ~rs2_q;
  assign scan_end  = (tcnt_q == TLAST);
  assign scan_done = scan_end && (col_q == 2'd3);
  assign cnt_inc   = cnt_q + CW'(1);

  // Lowest pressed row in the driven column gives its lowest key index.
  always_comb begin
    col_hit = 1'b0;
    col_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) begin
        col_hit = 1'b1;
        col_row = 2'(r);
      end
    end
    col_idx = {col_row, col_q};
    new_any = acc_any_q | col_hit;
    if (col_hit && (!acc_any_q || col_idx < acc_idx_q)) new_idx = col_idx;
    else                                                new_idx = acc_idx_q;
  end

`ifdef KEYPAD_MULTI_DETECT_EN
  logic [1:0] acc_cnt_q, new_cnt;
  logic [2:0] tot;

  always_comb begin
    tot = {1'b0, acc_cnt_q} + 3'(pressed[0]) + 3'(pressed[1])
        + 3'(pressed[2]) + 3'(pressed[3]);
    new_cnt   = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    new_multi = (new_cnt == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      acc_cnt_q <= 2'd0;
    else if (scan_end && col_q == 2'd3) acc_cnt_q <= 2'd0;
    else if (scan_end)               acc_cnt_q <= new_cnt;
  end
`else
  assign new_multi = 1'b0;
`endif

  assign single = new_any & ~new_multi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_q     <= 4'hF;
      rs2_q     <= 4'hF;
      tcnt_q    <= '0;
      col_q     <= 2'd0;
      acc_any_q <= 1'b0;
      acc_idx_q <= 4'd0;
    end else begin
      rs1_q <= kp.rows;
      rs2_q <= rs1_q;
      if (scan_end) begin
        tcnt_q <= '0;
        col_q  <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          acc_any_q <= 1'b0;
          acc_idx_q <= 4'd0;
        end else begin
          acc_any_q <= new_any;
          acc_idx_q <= new_idx;
        end
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    if (scan_done) begin
      case (state_q)
        IDLE: if (single) begin
          cand_d = new_idx;
          cnt_d  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            state_d = HELD;
            code_d  = new_idx;
          end else begin
            state_d = CAND;
          end
        end
        CAND: if (single && new_idx == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) begin
            state_d = HELD;
            code_d  = cand_q;
          end
        end else if (single) begin
          cand_d = new_idx;
          cnt_d  = CW'(1);
        end else begin
          state_d = IDLE;
        end
        HELD: if (!(single && new_idx == code_q)) begin
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE_SCANS == 1) ? IDLE : REL;
        end
        REL: if (single && new_idx == code_q) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    key_valid_d = (state_d == HELD) || (state_d == REL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      code_q      <= 4'd0;
      key_valid_q <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      code_q      <= code_d;
      key_valid_q <= key_valid_d;
      if (scan_done) multi_q <= new_multi;
    end
  end

  assign kp.cols      = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.multi_key = multi_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_TICKS=8, DEBOUNCE_SCANS=3)
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] press = 16'h0;
  int          checks = 0;
  int          failures = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kp.rows[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !kp.cols[c]) kp.rows[r] = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic do_reset(input logic [15:0] keys);
    rst_n = 1'b0;
    tick(3);
    press = keys;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(16'h0200);
    chk("rst_cols", kp.cols, 4'b1110);
    chk("rst_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("rst_code", kp.key_code, 4'd0);
    chk("rst_multi", {3'b0, kp.multi_key}, 4'd0);
    tick(100);
    chk("pre_rst_valid", {3'b0, kp.key_valid}, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("async_cols", kp.cols, 4'b1110);
    chk("async_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("async_code", kp.key_code, 4'd0);
    tick(2);
    rst_n = 1'b1;
    tick(7);
    chk("restart_col0", kp.cols, 4'b1110);
    tick(1);
    chk("restart_col1", kp.cols, 4'b1101);
    do_reset(16'h0000);
    tick(13);
    rst_n = 1'b0;
    #1;
    chk("mid_scan_cols", kp.cols, 4'b1110);
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_press;
    do_reset(16'h0200);
    tick(95);
    chk("press_95_valid", {3'b0, kp.key_valid}, 4'd0);
    tick(1);
    chk("press_96_valid", {3'b0, kp.key_valid}, 4'd1);
    chk("press_96_code", kp.key_code, 4'd9);
    chk("press_multi", {3'b0, kp.multi_key}, 4'd0);
  endtask

  task automatic test_glitch_and_release;
    do_reset(16'h0200);
    tick(32);
    press = 16'h0000;
    tick(32);
    press = 16'h0200;
    tick(64);
    chk("glitch_128_valid", {3'b0, kp.key_valid}, 4'd0);
    tick(31);
    chk("glitch_159_valid", {3'b0, kp.key_valid}, 4'd0);
    tick(1);
    chk("glitch_160_valid", {3'b0, kp.key_valid}, 4'd1);
    chk("glitch_160_code", kp.key_code, 4'd9);
    press = 16'h0000;
    tick(95);
    chk("rel_255_valid", {3'b0, kp.key_valid}, 4'd1);
    tick(1);
    chk("rel_256_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("rel_256_code", kp.key_code, 4'd9);
  endtask

  task automatic test_bounce;
    do_reset(16'h0200);
    tick(96);
    chk("bounce_held", {3'b0, kp.key_valid}, 4'd1);
    press = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      chk("bounce_gap_valid", {3'b0, kp.key_valid}, 4'd1);
    end
    press = 16'h0200;
    for (int i = 0; i < 72; i++) begin
      tick(1);
      chk("bounce_back_valid", {3'b0, kp.key_valid}, 4'd1);
    end
    chk("bounce_code", kp.key_code, 4'd9);
  endtask

  task automatic test_multi;
    do_reset(16'h0021);
    tick(31);
    chk("multi_31", {3'b0, kp.multi_key}, 4'd0);
    tick(1);
`ifdef KEYPAD_MULTI_DETECT_EN
    chk("multi_32", {3'b0, kp.multi_key}, 4'd1);
    tick(98);
    chk("multi_valid_low", {3'b0, kp.key_valid}, 4'd0);
    chk("multi_still", {3'b0, kp.multi_key}, 4'd1);
`else
    chk("multi_32_tied", {3'b0, kp.multi_key}, 4'd0);
    tick(63);
    chk("multi_95_valid", {3'b0, kp.key_valid}, 4'd0);
    tick(1);
    chk("multi_96_valid", {3'b0, kp.key_valid}, 4'd1);
    chk("multi_96_code", kp.key_code, 4'd0);
`endif
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch_and_release();
    test_bounce();
    test_multi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
